hazard_ctrl: RTL and testbench

//  Parametrised hazard/forwarding controller for the 5-stage RISC-V pipeline.

---
 rtl/hazard_ctrl.sv | 161 ++++++++++++++++
 tb/tb_hazard_ctrl.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// Hazard/forwarding controller for a 5-stage RISC-V pipeline: operand forwarding,
// load-use stall FSM, memory-wait freeze, branch flush and saturating perf counters.
module hazard_ctrl #(
    parameter int REG_AW   = 5,
    parameter int LOAD_LAT = 1,
    parameter int CNT_W    = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [REG_AW-1:0] rs1_d,
    input  logic [REG_AW-1:0] rs2_d,
    input  logic [REG_AW-1:0] rs1_e,
    input  logic [REG_AW-1:0] rs2_e,
    input  logic [REG_AW-1:0] rd_e,
    input  logic              mem_read_e,
    input  logic [REG_AW-1:0] rd_m,
    input  logic              reg_write_m,
    input  logic [REG_AW-1:0] rd_w,
    input  logic              reg_write_w,
    input  logic              pc_src_e,
    input  logic              mem_busy,
    input  logic              cnt_clr,
    output logic [1:0]        fwd_a_e,
    output logic [1:0]        fwd_b_e,
    output logic              stall_f,
    output logic              stall_d,
    output logic              stall_e,
    output logic              stall_m,
    output logic              flush_d,
    output logic              flush_e,
    output logic [CNT_W-1:0]  lu_stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);
    localparam int LW = $clog2(LOAD_LAT + 1);

    typedef enum logic {
        RUN      = 1'b0,
        LU_STALL = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [LW-1:0]    lu_left_q, lu_left_d;
    logic [CNT_W-1:0] lu_cnt_q, fl_cnt_q;

    logic lu_hit;
    logic lu_inc, fl_inc;
    logic stall_f_c, stall_d_c, stall_e_c, stall_m_c, flush_d_c, flush_e_c;

    function automatic logic [1:0] fwd_sel(
        input logic [REG_AW-1:0] rs,
        input logic [REG_AW-1:0] rdm,
        input logic              wm,
        input logic [REG_AW-1:0] rdw,
        input logic              ww
    );
        if (wm && (rdm != '0) && (rdm == rs)) begin
            return 2'b01;
        end else if (ww && (rdw != '0) && (rdw == rs)) begin
            return 2'b10;
        end
        return 2'b00;
    endfunction

    assign fwd_a_e = fwd_sel(rs1_e, rd_m, reg_write_m, rd_w, reg_write_w);
    assign fwd_b_e = fwd_sel(rs2_e, rd_m, reg_write_m, rd_w, reg_write_w);

    assign lu_hit = mem_read_e && (rd_e != '0) && ((rd_e == rs1_d) || (rd_e == rs2_d));

    always_comb begin
        state_d   = state_q;
        lu_left_d = lu_left_q;
        lu_inc    = 1'b0;
        fl_inc    = 1'b0;
        stall_f_c = 1'b0;
        stall_d_c = 1'b0;
        stall_e_c = 1'b0;
        stall_m_c = 1'b0;
        flush_d_c = 1'b0;
        flush_e_c = 1'b0;
        if (mem_busy) begin
            stall_f_c = 1'b1;
            stall_d_c = 1'b1;
            stall_e_c = 1'b1;
            stall_m_c = 1'b1;
        end else if (pc_src_e) begin
            // A load-use hit on the wrong path is dropped along with the flushed instructions.
            flush_d_c = 1'b1;
            flush_e_c = 1'b1;
            fl_inc    = 1'b1;
            state_d   = RUN;
            lu_left_d = '0;
        end else begin
            case (state_q)
                RUN: begin
                    if (lu_hit) begin
                        stall_f_c = 1'b1;
                        stall_d_c = 1'b1;
                        flush_e_c = 1'b1;
                        lu_inc    = 1'b1;
                        if (LOAD_LAT > 1) begin
                            state_d   = LU_STALL;
                            lu_left_d = LW'(LOAD_LAT - 1);
                        end
                    end
                end
                LU_STALL: begin
                    stall_f_c = 1'b1;
                    stall_d_c = 1'b1;
                    flush_e_c = 1'b1;
                    lu_inc    = 1'b1;
                    lu_left_d = lu_left_q - LW'(1);
                    if (lu_left_q == LW'(1)) begin
                        state_d = RUN;
                    end
                end
                default: begin
                    state_d   = RUN;
                    lu_left_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= RUN;
            lu_left_q <= '0;
        end else begin
            state_q   <= state_d;
            lu_left_q <= lu_left_d;
        end
    end

    // Clear wins over increment; increments stop at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lu_cnt_q <= '0;
            fl_cnt_q <= '0;
        end else if (cnt_clr) begin
            lu_cnt_q <= '0;
            fl_cnt_q <= '0;
        end else begin
            if (lu_inc && (lu_cnt_q != '1)) begin
                lu_cnt_q <= lu_cnt_q + CNT_W'(1);
            end
            if (fl_inc && (fl_cnt_q != '1)) begin
                fl_cnt_q <= fl_cnt_q + CNT_W'(1);
            end
        end
    end

    assign stall_f      = stall_f_c & rst_n;
    assign stall_d      = stall_d_c & rst_n;
    assign stall_e      = stall_e_c & rst_n;
    assign stall_m      = stall_m_c & rst_n;
    assign flush_d      = flush_d_c & rst_n;
    assign flush_e      = flush_e_c & rst_n;
    assign lu_stall_cnt = lu_cnt_q;
    assign flush_cnt    = fl_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: two instances (LOAD_LAT=2/CNT_W=16 and LOAD_LAT=3/CNT_W=4)
// share stimulus; table vectors, directed corner sequences and random cycles vs a model.
module tb_hazard_ctrl;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic [4:0] rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w;
    logic       mem_read_e, reg_write_m, reg_write_w, pc_src_e, mem_busy, cnt_clr;

    logic [1:0]  fwd_a [2];
    logic [1:0]  fwd_b [2];
    logic        stall_f [2];
    logic        stall_d [2];
    logic        stall_e [2];
    logic        stall_m [2];
    logic        flush_d [2];
    logic        flush_e [2];
    logic [15:0] lu_cnt0, fl_cnt0;
    logic [3:0]  lu_cnt1, fl_cnt1;

    hazard_ctrl #(.REG_AW(5), .LOAD_LAT(2), .CNT_W(16)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .rs1_d(rs1_d), .rs2_d(rs2_d), .rs1_e(rs1_e), .rs2_e(rs2_e),
        .rd_e(rd_e), .mem_read_e(mem_read_e), .rd_m(rd_m), .reg_write_m(reg_write_m),
        .rd_w(rd_w), .reg_write_w(reg_write_w), .pc_src_e(pc_src_e), .mem_busy(mem_busy),
        .cnt_clr(cnt_clr), .fwd_a_e(fwd_a[0]), .fwd_b_e(fwd_b[0]), .stall_f(stall_f[0]),
        .stall_d(stall_d[0]), .stall_e(stall_e[0]), .stall_m(stall_m[0]), .flush_d(flush_d[0]),
        .flush_e(flush_e[0]), .lu_stall_cnt(lu_cnt0), .flush_cnt(fl_cnt0)
    );

    hazard_ctrl #(.REG_AW(5), .LOAD_LAT(3), .CNT_W(4)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .rs1_d(rs1_d), .rs2_d(rs2_d), .rs1_e(rs1_e), .rs2_e(rs2_e),
        .rd_e(rd_e), .mem_read_e(mem_read_e), .rd_m(rd_m), .reg_write_m(reg_write_m),
        .rd_w(rd_w), .reg_write_w(reg_write_w), .pc_src_e(pc_src_e), .mem_busy(mem_busy),
        .cnt_clr(cnt_clr), .fwd_a_e(fwd_a[1]), .fwd_b_e(fwd_b[1]), .stall_f(stall_f[1]),
        .stall_d(stall_d[1]), .stall_e(stall_e[1]), .stall_m(stall_m[1]), .flush_d(flush_d[1]),
        .flush_e(flush_e[1]), .lu_stall_cnt(lu_cnt1), .flush_cnt(fl_cnt1)
    );

    logic [9:0]  act_o  [2];
    logic [15:0] act_lu [2];
    logic [15:0] act_fl [2];
    assign act_o[0]  = {fwd_a[0], fwd_b[0], stall_f[0], stall_d[0], stall_e[0], stall_m[0],
                        flush_d[0], flush_e[0]};
    assign act_o[1]  = {fwd_a[1], fwd_b[1], stall_f[1], stall_d[1], stall_e[1], stall_m[1],
                        flush_d[1], flush_e[1]};
    assign act_lu[0] = lu_cnt0;
    assign act_fl[0] = fl_cnt0;
    assign act_lu[1] = {12'b0, lu_cnt1};
    assign act_fl[1] = {12'b0, fl_cnt1};

    int total = 0;
    int bad   = 0;

    // Reference model: remaining stall cycles of the current hazard plus plain counters.
    int lat  [2] = '{2, 3};
    int cmax [2] = '{65535, 15};
    int rem  [2];
    int m_lu [2];
    int m_fl [2];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [1:0] exp_fwd(input logic [4:0] rs);
        if (reg_write_m && rd_m != 0 && rd_m == rs) return 2'b01;
        if (reg_write_w && rd_w != 0 && rd_w == rs) return 2'b10;
        return 2'b00;
    endfunction

    function automatic logic lu_hit_m();
        return mem_read_e && rd_e != 0 && (rd_e == rs1_d || rd_e == rs2_d);
    endfunction

    function automatic logic [9:0] exp_out(input int d);
        logic [5:0] ctl;
        ctl = 6'b0;
        if (!rst_n)                          ctl = 6'b000000;
        else if (mem_busy)                   ctl = 6'b111100;
        else if (pc_src_e)                   ctl = 6'b000011;
        else if (rem[d] > 0 || lu_hit_m())   ctl = 6'b110001;
        return {exp_fwd(rs1_e), exp_fwd(rs2_e), ctl};
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            rem[d] = 0; m_lu[d] = 0; m_fl[d] = 0;
        end
    endtask

    task automatic model_update();
        for (int d = 0; d < 2; d++) begin
            int lu_inc, fl_inc;
            lu_inc = 0; fl_inc = 0;
            if (!rst_n) begin
                rem[d] = 0; m_lu[d] = 0; m_fl[d] = 0;
                continue;
            end
            if (!mem_busy) begin
                if (pc_src_e) begin
                    rem[d] = 0; fl_inc = 1;
                end else if (rem[d] > 0) begin
                    rem[d]--; lu_inc = 1;
                end else if (lu_hit_m()) begin
                    rem[d] = lat[d] - 1; lu_inc = 1;
                end
            end
            if (cnt_clr) begin
                m_lu[d] = 0; m_fl[d] = 0;
            end else begin
                if (lu_inc == 1 && m_lu[d] < cmax[d]) m_lu[d]++;
                if (fl_inc == 1 && m_fl[d] < cmax[d]) m_fl[d]++;
            end
        end
    endtask

    // Called at posedge+1 with inputs applied; returns at the falling edge after checking.
    task automatic settle();
        if (!rst_n) model_reset();
        #4;
        for (int d = 0; d < 2; d++) begin
            check($sformatf("outs%0d", d), 32'(act_o[d]), 32'(exp_out(d)));
            check($sformatf("lucnt%0d", d), 32'(act_lu[d]), 32'(m_lu[d]));
            check($sformatf("flcnt%0d", d), 32'(act_fl[d]), 32'(m_fl[d]));
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic idle();
        rst_n = 1'b1; rs1_d = 0; rs2_d = 0; rs1_e = 0; rs2_e = 0; rd_e = 0; rd_m = 0; rd_w = 0;
        mem_read_e = 0; reg_write_m = 0; reg_write_w = 0; pc_src_e = 0; mem_busy = 0; cnt_clr = 0;
    endtask

    task automatic do_reset();
        idle();
        rst_n = 1'b0;
        settle();
        tick();
        idle();
    endtask

    task automatic load_use(input logic [4:0] r);
        mem_read_e = 1'b1; rd_e = r; rs2_d = r;
    endtask

    typedef struct {
        logic [4:0] rs1_e, rs2_e, rd_m;
        logic       wm;
        logic [4:0] rd_w;
        logic       ww;
        logic [1:0] ea, eb;
    } fv_t;

    fv_t tbl [8];

    initial begin
        tbl[0] = '{5'd5,  5'd0,  5'd5,  1'b1, 5'd5,  1'b1, 2'b01, 2'b00};
        tbl[1] = '{5'd5,  5'd0,  5'd5,  1'b0, 5'd5,  1'b1, 2'b10, 2'b00};
        tbl[2] = '{5'd3,  5'd0,  5'd0,  1'b1, 5'd9,  1'b1, 2'b00, 2'b00};
        tbl[3] = '{5'd4,  5'd0,  5'd4,  1'b1, 5'd0,  1'b1, 2'b01, 2'b00};
        tbl[4] = '{5'd9,  5'd12, 5'd12, 1'b1, 5'd9,  1'b1, 2'b10, 2'b01};
        tbl[5] = '{5'd9,  5'd9,  5'd9,  1'b0, 5'd9,  1'b0, 2'b00, 2'b00};
        tbl[6] = '{5'd31, 5'd31, 5'd31, 1'b1, 5'd31, 1'b1, 2'b01, 2'b01};
        tbl[7] = '{5'd17, 5'd1,  5'd16, 1'b1, 5'd1,  1'b1, 2'b00, 2'b10};

        // Reset with hostile inputs: controls must stay low.
        idle();
        rst_n = 1'b0; mem_busy = 1'b1; pc_src_e = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        settle();
        check("rst_stall_m", 32'(stall_m[0]), 32'd0);
        check("rst_flush_d", 32'(flush_d[1]), 32'd0);
        tick();
        idle();

        for (int i = 0; i < 8; i++) begin
            rs1_e = tbl[i].rs1_e; rs2_e = tbl[i].rs2_e; rd_m = tbl[i].rd_m;
            reg_write_m = tbl[i].wm; rd_w = tbl[i].rd_w; reg_write_w = tbl[i].ww;
            settle();
            for (int d = 0; d < 2; d++) begin
                check($sformatf("tbl%0d_fwd_a%0d", i, d), 32'(fwd_a[d]), 32'(tbl[i].ea));
                check($sformatf("tbl%0d_fwd_b%0d", i, d), 32'(fwd_b[d]), 32'(tbl[i].eb));
            end
            tick();
        end

        // LOAD_LAT=2: exactly two stall cycles for one hazard.
        do_reset();
        load_use(5'd7);
        settle();
        check("lu2_c0_stall_f", 32'(stall_f[0]), 32'd1);
        check("lu2_c0_flush_e", 32'(flush_e[0]), 32'd1);
        check("lu2_c0_stall_e", 32'(stall_e[0]), 32'd0);
        tick();
        idle();
        settle();
        check("lu2_c1_stall_d", 32'(stall_d[0]), 32'd1);
        check("lu2_c1_flush_e", 32'(flush_e[0]), 32'd1);
        tick();
        settle();
        check("lu2_c2_stall_f", 32'(stall_f[0]), 32'd0);
        check("lu2_c2_flush_e", 32'(flush_e[0]), 32'd0);
        check("lu2_cnt", 32'(lu_cnt0), 32'd2);
        tick();

        // Branch and load-use in the same cycle: flush wins, hazard discarded.
        do_reset();
        load_use(5'd7);
        rs1_d = 5'd7;
        pc_src_e = 1'b1;
        settle();
        check("br_flush_d", 32'(flush_d[0]), 32'd1);
        check("br_flush_e", 32'(flush_e[0]), 32'd1);
        check("br_stall_f", 32'(stall_f[0]), 32'd0);
        tick();
        idle();
        settle();
        check("br_after_stall_f", 32'(stall_f[1]), 32'd0);
        check("br_after_flush_e", 32'(flush_e[0]), 32'd0);
        check("br_fl_cnt", 32'(fl_cnt0), 32'd1);
        check("br_lu_cnt", 32'(lu_cnt0), 32'd0);
        tick();

        // LOAD_LAT=3 with a 3-cycle freeze after the first stall cycle.
        do_reset();
        load_use(5'd7);
        settle();
        check("frz_c0_stall_f", 32'(stall_f[1]), 32'd1);
        tick();
        idle();
        mem_busy = 1'b1;
        for (int k = 0; k < 3; k++) begin
            settle();
            check($sformatf("frz%0d_stall_e", k), 32'(stall_e[1]), 32'd1);
            check($sformatf("frz%0d_stall_m", k), 32'(stall_m[1]), 32'd1);
            check($sformatf("frz%0d_flush_e", k), 32'(flush_e[1]), 32'd0);
            check($sformatf("frz%0d_lu_cnt", k), 32'(lu_cnt1), 32'd1);
            tick();
        end
        mem_busy = 1'b0;
        for (int k = 0; k < 2; k++) begin
            settle();
            check($sformatf("frz_post%0d_stall_f", k), 32'(stall_f[1]), 32'd1);
            check($sformatf("frz_post%0d_flush_e", k), 32'(flush_e[1]), 32'd1);
            tick();
        end
        settle();
        check("frz_end_stall_f", 32'(stall_f[1]), 32'd0);
        check("frz_lu_cnt", 32'(lu_cnt1), 32'd3);
        tick();

        // Reset while in the stall state aborts it.
        do_reset();
        load_use(5'd7);
        settle();
        tick();
        idle();
        settle();
        check("rs_mid_stall_f", 32'(stall_f[1]), 32'd1);
        rst_n = 1'b0;
        mem_busy = 1'b1;
        settle();
        check("rs_in_stall_f", 32'(stall_f[1]), 32'd0);
        check("rs_in_stall_m", 32'(stall_m[1]), 32'd0);
        check("rs_in_flush_e", 32'(flush_e[1]), 32'd0);
        check("rs_in_lu_cnt", 32'(lu_cnt1), 32'd0);
        tick();
        idle();
        settle();
        check("rs_rel_stall_f", 32'(stall_f[1]), 32'd0);
        check("rs_rel_flush_e", 32'(flush_e[1]), 32'd0);
        tick();

        // Saturation of the 4-bit counter and synchronous clear.
        do_reset();
        pc_src_e = 1'b1;
        repeat (20) begin
            settle();
            tick();
        end
        idle();
        settle();
        check("sat_fl_cnt4", 32'(fl_cnt1), 32'd15);
        check("sat_fl_cnt16", 32'(fl_cnt0), 32'd20);
        tick();
        cnt_clr = 1'b1;
        settle();
        tick();
        cnt_clr = 1'b0;
        settle();
        check("clr_fl_cnt4", 32'(fl_cnt1), 32'd0);
        check("clr_fl_cnt16", 32'(fl_cnt0), 32'd0);
        tick();

        // Random traffic against the model.
        repeat (600) begin
            rst_n       = ($urandom_range(0, 59) != 0);
            rs1_d       = 5'($urandom_range(0, 7));
            rs2_d       = 5'($urandom_range(0, 7));
            rs1_e       = 5'($urandom_range(0, 7));
            rs2_e       = 5'($urandom_range(0, 7));
            rd_e        = 5'($urandom_range(0, 7));
            rd_m        = 5'($urandom_range(0, 7));
            rd_w        = 5'($urandom_range(0, 7));
            mem_read_e  = 1'($urandom_range(0, 1));
            reg_write_m = 1'($urandom_range(0, 1));
            reg_write_w = 1'($urandom_range(0, 1));
            pc_src_e    = ($urandom_range(0, 9) == 0);
            mem_busy    = ($urandom_range(0, 6) == 0);
            cnt_clr     = ($urandom_range(0, 39) == 0);
            settle();
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
